// File: rtl/mem_bus_responder_if.sv
// CPU memory bus plus downstream TX valid/ready channel for mem_bus_responder.
// master = CPU/consumer side, slave = responder side.
interface mem_bus_responder_if;
   logic [15:0] addr_in;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        ram_wr;
   logic        ram_oe;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output addr_in, data_in, ram_wr, ram_oe, tx_ready,
      input  data_out, tx_data, tx_valid
   );

   modport slave (
      input  addr_in, data_in, ram_wr, ram_oe, tx_ready,
      output data_out, tx_data, tx_valid
   );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory bus responder: byte RAM, TX data port into a FIFO, sticky status register.
// Optional write protection of the low RAM region below ROM_TOP is enabled by defining ROM_WP_EN.
module mem_bus_responder #(
   parameter int          RAM_AW  = 8,
   parameter logic [15:0] IO_BASE = 16'hFF00,
   parameter int          FIFO_AW = 3,
   parameter logic [15:0] ROM_TOP = 16'h0040
) (
   input  logic               clk,
   input  logic               reset,
   mem_bus_responder_if.slave bus
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   logic [7:0]         ram_mem  [2**RAM_AW];
   logic [7:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] rd_ptr_reg;
   logic [FIFO_AW-1:0] wr_ptr_reg;
   logic [CW-1:0]      count_reg;
   logic               ovf_reg;
   logic               wpf;

   logic is_ram, is_txd, is_stat;
   logic full, empty, push, pop, push_ok, stat_rd, wp_hit;
   logic [3:0] count_ext;

   assign is_ram  = (bus.addr_in >> RAM_AW) == 16'd0;
   assign is_txd  = bus.addr_in == IO_BASE;
   assign is_stat = bus.addr_in == (IO_BASE + 16'd1);

   assign full      = count_reg == CW'(DEPTH);
   assign empty     = count_reg == '0;
   assign count_ext = 4'(count_reg);

   // Pop is resolved first, so a full FIFO still accepts a push on a draining edge.
   assign pop     = !empty && bus.tx_ready;
   assign push    = bus.ram_wr && is_txd;
   assign push_ok = push && (!full || pop);
   assign stat_rd = bus.ram_oe && is_stat;

`ifdef ROM_WP_EN
   logic wpf_reg;
   assign wp_hit = is_ram && (bus.addr_in < ROM_TOP);
   assign wpf    = wpf_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wpf_reg <= 1'b0;
      else if (bus.ram_wr && wp_hit)
         wpf_reg <= 1'b1;
      else if (stat_rd)
         wpf_reg <= 1'b0;
   end
`else
   logic unused_rom_top;
   assign unused_rom_top = ^ROM_TOP;
   assign wp_hit         = 1'b0;
   assign wpf            = 1'b0;
`endif

   // Storage arrays are deliberately not reset; RAM survives a reset.
   always_ff @(posedge clk) begin
      if (bus.ram_wr && is_ram && !wp_hit)
         ram_mem[bus.addr_in[RAM_AW-1:0]] <= bus.data_in;
      if (push_ok)
         fifo_mem[wr_ptr_reg] <= bus.data_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(push_ok) - CW'(pop);
         if (push && !push_ok)
            ovf_reg <= 1'b1;
         else if (stat_rd)
            ovf_reg <= 1'b0;
      end
   end

   assign bus.tx_valid = !empty;
   assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr_reg];

   always_comb begin
      bus.data_out = 8'h00;
      if (!reset && bus.ram_oe) begin
         if (is_ram)
            bus.data_out = ram_mem[bus.addr_in[RAM_AW-1:0]];
         else if (is_txd)
            bus.data_out = 8'h00;
         else if (is_stat)
            bus.data_out = {ovf_reg, wpf, full, empty, count_ext};
         else
            bus.data_out = 8'hFF;
      end
   end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder; a negedge scoreboard tracks every byte pushed
// to the TX port and checks it when the consumer handshake takes it.
module tb_mem_bus_responder;
   localparam logic [15:0] IO_BASE = 16'hFF00;
   localparam logic [15:0] STAT    = 16'hFF01;
   localparam int          DEPTH   = 8;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   logic [7:0] exp_q[$];

   mem_bus_responder_if bus_if ();

   mem_bus_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: inputs are only changed just after posedge, so negedge values are what the next edge sees.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         n_cmp++;
         if (bus_if.tx_valid !== (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL sb_tx_valid: got %b want %b", bus_if.tx_valid, exp_q.size() != 0);
         end
         if (exp_q.size() != 0 && bus_if.tx_ready) begin
            n_cmp++;
            if (bus_if.tx_data !== exp_q[0]) begin
               n_bad++;
               $display("FAIL sb_tx_data: got %02h want %02h", bus_if.tx_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         if (bus_if.ram_wr && bus_if.addr_in == IO_BASE && exp_q.size() < DEPTH)
            exp_q.push_back(bus_if.data_in);
      end
   end

   // Bus drivers: called and returning just after a posedge.
   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus_if.addr_in = a;
      bus_if.data_in = d;
      bus_if.ram_wr  = 1'b1;
      bus_if.ram_oe  = 1'b0;
      @(posedge clk);
      #1;
      bus_if.ram_wr = 1'b0;
      $display("write addr=%04h data=%02h", a, d);
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      bus_if.addr_in = a;
      bus_if.ram_wr  = 1'b0;
      bus_if.ram_oe  = 1'b1;
      @(negedge clk);
      d = bus_if.data_out;
      @(posedge clk);
      #1;
      bus_if.ram_oe = 1'b0;
      $display("read  addr=%04h data=%02h", a, d);
   endtask

   task automatic drain_all();
      int i;
      bus_if.tx_ready = 1'b1;
      for (i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      bus_if.tx_ready = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d bytes left want 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00 || bus_if.data_out !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%b data=%02h dout=%02h want 0/00/00",
                  bus_if.tx_valid, bus_if.tx_data, bus_if.data_out);
      end
      reset = 1'b0;
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL reset_stat: got %02h want 10", rd); end
   endtask

   task automatic test_ram();
      logic [7:0] rd;
      cpu_write(16'h0010, 8'hA5);
      cpu_read(16'h0010, rd);
      n_cmp++;
      if (rd !== 8'hA5) begin n_bad++; $display("FAIL ram_rd: got %02h want a5", rd); end
      bus_if.addr_in = 16'h0010;
      bus_if.ram_oe  = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus_if.data_out !== 8'h00) begin
         n_bad++; $display("FAIL ram_oe_low: got %02h want 00", bus_if.data_out);
      end
      @(posedge clk);
      #1;
      cpu_write(16'h00FF, 8'h3C);
      cpu_read(16'h00FF, rd);
      n_cmp++;
      if (rd !== 8'h3C) begin n_bad++; $display("FAIL ram_top: got %02h want 3c", rd); end
      // Simultaneous read and write shows the old byte.
      bus_if.addr_in = 16'h0010;
      bus_if.data_in = 8'h5A;
      bus_if.ram_wr  = 1'b1;
      bus_if.ram_oe  = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus_if.data_out !== 8'hA5) begin
         n_bad++; $display("FAIL ram_rw_same: got %02h want a5", bus_if.data_out);
      end
      @(posedge clk);
      #1;
      bus_if.ram_wr = 1'b0;
      bus_if.ram_oe = 1'b0;
      cpu_read(16'h0010, rd);
      n_cmp++;
      if (rd !== 8'h5A) begin n_bad++; $display("FAIL ram_rw_after: got %02h want 5a", rd); end
   endtask

   task automatic test_fifo_basic();
      logic [7:0] rd;
      bus_if.tx_ready = 1'b0;
      cpu_write(IO_BASE, 8'h11);
      cpu_write(IO_BASE, 8'h22);
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h02) begin n_bad++; $display("FAIL fifo_stat2: got %02h want 02", rd); end
      n_cmp++;
      if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h11) begin
         n_bad++; $display("FAIL fifo_head: valid=%b data=%02h want 1/11", bus_if.tx_valid, bus_if.tx_data);
      end
      bus_if.tx_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus_if.tx_data !== 8'h11) begin n_bad++; $display("FAIL drain_1: got %02h want 11", bus_if.tx_data); end
      @(negedge clk);
      n_cmp++;
      if (bus_if.tx_data !== 8'h22) begin n_bad++; $display("FAIL drain_2: got %02h want 22", bus_if.tx_data); end
      @(negedge clk);
      n_cmp++;
      if (bus_if.tx_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", bus_if.tx_valid); end
      @(posedge clk);
      #1;
      bus_if.tx_ready = 1'b0;
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL fifo_stat_empty: got %02h want 10", rd); end
   endtask

   task automatic test_overflow();
      logic [7:0] rd;
      bus_if.tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) cpu_write(IO_BASE, 8'h30 + 8'(i));
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'hA8) begin n_bad++; $display("FAIL ovf_stat: got %02h want a8", rd); end
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h28) begin n_bad++; $display("FAIL ovf_clear: got %02h want 28", rd); end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] rd;
      bus_if.tx_ready = 1'b1;
      cpu_write(IO_BASE, 8'h77);
      bus_if.tx_ready = 1'b0;
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h28) begin n_bad++; $display("FAIL full_pushpop: got %02h want 28", rd); end
      drain_all();
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL full_drained: got %02h want 10", rd); end
   endtask

   task automatic test_decode_and_reset();
      logic [7:0] rd;
      cpu_write(16'h0034, 8'h00);
      cpu_read(16'h1234, rd);
      n_cmp++;
      if (rd !== 8'hFF) begin n_bad++; $display("FAIL unmapped_rd: got %02h want ff", rd); end
      cpu_read(16'h0100, rd);
      n_cmp++;
      if (rd !== 8'hFF) begin n_bad++; $display("FAIL above_ram: got %02h want ff", rd); end
      cpu_read(IO_BASE, rd);
      n_cmp++;
      if (rd !== 8'h00) begin n_bad++; $display("FAIL txd_rd: got %02h want 00", rd); end
      cpu_write(16'h1234, 8'h99);
      cpu_read(16'h0034, rd);
      n_cmp++;
      if (rd !== 8'h00) begin n_bad++; $display("FAIL unmapped_alias: got %02h want 00", rd); end
      cpu_write(STAT, 8'hFF);
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL stat_wr: got %02h want 10", rd); end
      // Reset in the middle of a drain.
      cpu_write(IO_BASE, 8'hC1);
      cpu_write(IO_BASE, 8'hC2);
      cpu_write(IO_BASE, 8'hC3);
      bus_if.tx_ready = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00) begin
         n_bad++; $display("FAIL mid_reset: valid=%b data=%02h want 0/00", bus_if.tx_valid, bus_if.tx_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_if.tx_ready = 1'b0;
      $display("reset pulse during drain");
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL post_reset_stat: got %02h want 10", rd); end
      cpu_read(16'h0010, rd);
      n_cmp++;
      if (rd !== 8'h5A) begin n_bad++; $display("FAIL ram_retained: got %02h want 5a", rd); end
   endtask

`ifdef ROM_WP_EN
   task automatic test_rom_wp();
      logic [7:0] before, rd;
      cpu_read(16'h0020, before);
      cpu_write(16'h0020, 8'h55);
      cpu_read(16'h0020, rd);
      n_cmp++;
      if (rd !== before) begin n_bad++; $display("FAIL wp_kept: got %02h want %02h", rd, before); end
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h50) begin n_bad++; $display("FAIL wp_stat: got %02h want 50", rd); end
      cpu_read(STAT, rd);
      n_cmp++;
      if (rd !== 8'h10) begin n_bad++; $display("FAIL wp_clear: got %02h want 10", rd); end
      cpu_write(16'h0040, 8'h55);
      cpu_read(16'h0040, rd);
      n_cmp++;
      if (rd !== 8'h55) begin n_bad++; $display("FAIL wp_top: got %02h want 55", rd); end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus_if.addr_in  = 16'h0000;
      bus_if.data_in  = 8'h00;
      bus_if.ram_wr   = 1'b0;
      bus_if.ram_oe   = 1'b0;
      bus_if.tx_ready = 1'b0;
      test_reset();
      test_ram();
      test_fifo_basic();
      test_overflow();
      test_push_pop_full();
      test_decode_and_reset();
`ifdef ROM_WP_EN
      test_rom_wp();
`endif
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
